// File: rtl/seq_pkg.sv
// Shared step-sequencer constants and FSM state type; no logic, no latency.
package seq_pkg;

    localparam int NUM_STEPS = 16;
    localparam int STEP_W    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } seq_state_t;

endpackage

// File: rtl/tick_divider.sv
// Tempo counter: counts 0..TICKS-1 while enabled; wrap is a same-cycle decode of the last count.
// clear has priority over enable; there is no backpressure.
module tick_divider #(
    parameter int TICKS = 12500000,
    parameter int CW    = $clog2(TICKS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          wrap
);

    assign wrap = enable && (count == CW'(TICKS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// 16-step note sequencer with registered gate output; all outputs change one edge after their cause.
// Optional SEQ_LOOP_EN loops step 15 -> 0; otherwise the pass ends in IDLE. No backpressure.
module step_sequencer
    import seq_pkg::*;
#(
    parameter int STEP_TICKS = 12500000,
    parameter int GATE_TICKS = 9375000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              stop,
    input  logic              wr_en,
    input  logic [STEP_W-1:0] wr_addr,
    input  logic              wr_data,
    output logic              sound,
    output logic [STEP_W-1:0] step,
    output logic              playing,
    output logic              step_tick
);

    localparam int CW = $clog2(STEP_TICKS);
    localparam logic [CW:0] GATE_V = (CW + 1)'(GATE_TICKS);

    seq_state_t              state;
    logic [NUM_STEPS-1:0]    pattern;
    logic                    note;
    logic [CW-1:0]           tick_cnt;
    logic                    tick_wrap;
    logic                    tick_clear;
    logic                    tick_enable;
    logic                    seq_end;
    logic                    gate_nxt;
    logic [STEP_W-1:0]       next_step;
    logic [CW:0]             tick_inc;

    assign next_step = step + STEP_W'(1);
    assign tick_inc  = {1'b0, tick_cnt} + (CW + 1)'(1);
    // Gate is evaluated for the count value the next cycle will show.
    assign gate_nxt  = tick_inc < GATE_V;

`ifdef SEQ_LOOP_EN
    assign seq_end = 1'b0;
`else
    assign seq_end = tick_wrap && (step == STEP_W'(NUM_STEPS - 1));
`endif

    assign tick_enable = (state == PLAY);
    assign tick_clear  = (state != PLAY) || stop || seq_end;

    tick_divider #(
        .TICKS (STEP_TICKS),
        .CW    (CW)
    ) u_tick_divider (
        .clk    (clk),
        .reset  (reset),
        .clear  (tick_clear),
        .enable (tick_enable),
        .count  (tick_cnt),
        .wrap   (tick_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pattern   <= '0;
            note      <= 1'b0;
            step      <= '0;
            sound     <= 1'b0;
            step_tick <= 1'b0;
            playing   <= 1'b0;
        end else begin
            // Note latches below read the pre-write pattern at this edge.
            if (wr_en) begin
                pattern[wr_addr] <= wr_data;
            end
            case (state)
                IDLE: begin
                    if (play && !stop) begin
                        state     <= PLAY;
                        playing   <= 1'b1;
                        step      <= '0;
                        note      <= pattern[0];
                        sound     <= pattern[0];
                        step_tick <= 1'b0;
                    end
                end
                PLAY: begin
                    if (stop || seq_end) begin
                        state     <= IDLE;
                        playing   <= 1'b0;
                        step      <= '0;
                        note      <= 1'b0;
                        sound     <= 1'b0;
                        step_tick <= 1'b0;
                    end else if (tick_wrap) begin
                        step      <= next_step;
                        note      <= pattern[next_step];
                        sound     <= pattern[next_step];
                        step_tick <= 1'b0;
                    end else begin
                        sound     <= note & gate_nxt;
                        // High during the last cycle of each step, i.e. on the advancing edge.
                        step_tick <= (tick_cnt == CW'(STEP_TICKS - 2));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer with STEP_TICKS=4, GATE_TICKS=3: directed scenarios plus random traffic
// checked every cycle against a position-in-sequence reference model.
module tb_step_sequencer;

    localparam int ST = 4;
    localparam int GT = 3;
    localparam int NS = 16;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       play    = 1'b0;
    logic       stop    = 1'b0;
    logic       wr_en   = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic       wr_data = 1'b0;
    logic       sound;
    logic [3:0] step;
    logic       playing;
    logic       step_tick;

    step_sequencer #(
        .STEP_TICKS (ST),
        .GATE_TICKS (GT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .stop      (stop),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .sound     (sound),
        .step      (step),
        .playing   (playing),
        .step_tick (step_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: pattern contents, playing flag, cycles elapsed in the pass, latched note.
    bit [15:0] m_pat  = 16'h0;
    bit        m_play = 1'b0;
    int        m_pos  = 0;
    bit        m_note = 1'b0;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit [15:0] old_pat;
        old_pat = m_pat;
        if (wr_en) m_pat[wr_addr] = wr_data;
        if (!m_play) begin
            if (play && !stop) begin
                m_play = 1'b1;
                m_pos  = 0;
                m_note = old_pat[0];
            end
        end else if (stop) begin
            m_play = 1'b0;
            m_pos  = 0;
        end else begin
            m_pos++;
            if (m_pos == ST * NS) begin
`ifdef SEQ_LOOP_EN
                m_pos = 0;
`else
                m_play = 1'b0;
                m_pos  = 0;
`endif
            end
            if (m_play && (m_pos % ST == 0)) m_note = old_pat[m_pos / ST];
        end
    endtask

    task automatic check_outputs(input string tag);
        bit       e_sound;
        bit       e_tick;
        bit [3:0] e_step;
        e_sound = m_play && m_note && ((m_pos % ST) < GT);
        e_tick  = m_play && ((m_pos % ST) == ST - 1);
        e_step  = m_play ? 4'(m_pos / ST) : 4'd0;
        check({tag, " playing"}, {3'b0, playing}, {3'b0, m_play});
        check({tag, " step"}, step, e_step);
        check({tag, " sound"}, {3'b0, sound}, {3'b0, e_sound});
        check({tag, " step_tick"}, {3'b0, step_tick}, {3'b0, e_tick});
    endtask

    task automatic cyc(input bit p, input bit s, input bit we, input logic [3:0] wa, input bit wd);
        play = p; stop = s; wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        model_edge();
        #1 check_outputs("cyc");
    endtask

    initial begin
        logic [15:0] pat29;
        logic [11:0] snd29;
        logic [11:0] tck29;
        int guard;

        pat29 = 16'h0005;
        snd29 = 12'b1110_0000_1110;
        tck29 = 12'b0001_0001_0001;

        // Reset state
        #11;
        check_outputs("reset");
        reset = 1'b0;
        #1;

        // Basic pattern 0x0005 with explicit expected gate sequence
        for (int i = 0; i < NS; i++) cyc(1'b0, 1'b0, 1'b1, 4'(i), pat29[i]);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            check("basic sound", {3'b0, sound}, {3'b0, snd29[11-k]});
            check("basic step_tick", {3'b0, step_tick}, {3'b0, tck29[11-k]});
            check("basic step", step, 4'(k / 4));
            cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        end
        // play while playing must not restart
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // play and stop together in IDLE
        cyc(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        check("play_stop playing", {3'b0, playing}, 4'd0);
        check("play_stop sound", {3'b0, sound}, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // stop at step 5 tick 1, then restart
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        guard = 0;
        while (m_pos != 5 * ST + 1 && guard < 200) begin
            cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            guard++;
        end
        check("reach step5 in budget", {3'b0, 1'(guard < 200)}, 4'd1);
        check("at step5", step, 4'd5);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        check("stop step", step, 4'd0);
        check("stop playing", {3'b0, playing}, 4'd0);
        check("stop sound", {3'b0, sound}, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        check("restart step", step, 4'd0);
        check("restart playing", {3'b0, playing}, 4'd1);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // write pattern[3] on the edge that latches step 3, then run through the wrap
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        guard = 0;
        while (m_pos != 3 * ST - 1 && guard < 200) begin
            cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            guard++;
        end
        cyc(1'b0, 1'b0, 1'b1, 4'd3, 1'b1);
        check("late write step", step, 4'd3);
        check("late write silent", {3'b0, sound}, 4'd0);
        guard = 0;
        while (m_pos != ST * NS - 1 && guard < 200) begin
            cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            guard++;
        end
        check("last step", step, 4'd15);
        check("last step tick", {3'b0, step_tick}, 4'd1);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
`ifdef SEQ_LOOP_EN
        check("wrap step", step, 4'd0);
        check("wrap playing", {3'b0, playing}, 4'd1);
        guard = 0;
        while (m_pos != 3 * ST && guard < 200) begin
            cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            guard++;
        end
        check("second pass step3 sounds", {3'b0, sound}, 4'd1);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
`else
        check("end playing", {3'b0, playing}, 4'd0);
        check("end sound", {3'b0, sound}, 4'd0);
        check("end step", step, 4'd0);
`endif

        // random traffic
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // reset mid-note
        for (int i = 0; i < NS; i++) cyc(1'b0, 1'b0, 1'b1, 4'(i), 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        check("mid-note sound", {3'b0, sound}, 4'd1);
        #2 reset = 1'b1;
        m_pat = 16'h0; m_play = 1'b0; m_pos = 0; m_note = 1'b0;
        #1 check_outputs("async reset");
        #1 reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        check("post reset playing", {3'b0, playing}, 4'd1);
        for (int k = 0; k < 2 * ST; k++) begin
            check("post reset silence", {3'b0, sound}, 4'd0);
            cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
